// File: rtl/ahb_gpio_evtfifo_pkg.sv
// ---------------------------------------------------------------------------
// ahb_gpio_evtfifo_pkg
//   Shared definitions for the GPIO change-event FIFO subordinate:
//   register offsets (HADDR[3:2]), bit positions inside the registers and
//   the packed event record stored in the FIFO.
// ---------------------------------------------------------------------------
package ahb_gpio_evtfifo_pkg;

    // Register offsets decoded from HADDR[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    // DATA register
    localparam int DATA_VALID_BIT  = 31;

    // STATUS register (count occupies the low bits)
    localparam int STATUS_OVF_BIT  = 8;
    localparam int STATUS_PERR_BIT = 9;

    // CTRL register
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQEN_BIT  = 1;

    // CLEAR register
    localparam int CLR_FLUSH_BIT   = 0;
    localparam int CLR_OVF_BIT     = 1;
    localparam int CLR_PERR_BIT    = 2;

    // One captured change: parity-error flag above the 16 data bits
    localparam int EVT_W = 17;

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } evt_t;

endpackage

// File: rtl/ahb_gpio_evtfifo_fifo.sv
// ---------------------------------------------------------------------------
// evt_fifo
//   Synchronous FIFO with push / pop / flush. Flush has priority over push
//   and pop. A pop on an empty FIFO is ignored; a push on a full FIFO is
//   accepted only when a pop happens in the same cycle.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     push, wdata       write request and data
//     pop, rdata        read request and head-of-queue data (show-ahead)
//     flush             empty the FIFO
//     full, empty       occupancy flags
//     count             number of held entries, 0..DEPTH
// ---------------------------------------------------------------------------
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == PW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);   // wraps modulo DEPTH
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; only pointers/count define validity, so a reset here buys nothing.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ahb_gpio_evtfifo.sv
// ---------------------------------------------------------------------------
// ahb_gpio_evtfifo
//   AHB-Lite subordinate that captures every change on a 17-bit GPIO input
//   (16 data bits + parity), checks parity, and queues the change events in
//   a FIFO for the CPU to drain. IRQ is raised while events are pending or
//   an overflow is latched (when irq_en is set).
//   Ports:
//     HCLK, HRESET                  clock, synchronous active-high reset
//     HSEL, HADDR, HTRANS, HWRITE   AHB-Lite address phase
//     HWDATA, HREADY                AHB-Lite data phase / bus ready
//     HREADYOUT, HRDATA             response (zero wait states)
//     GPIOIN, PARITYSEL             monitored bus, 0 = even / 1 = odd parity
//     PARITYERR, IRQ                sticky parity error, interrupt
// ---------------------------------------------------------------------------
module ahb_gpio_evtfifo
    import ahb_gpio_evtfifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    input  logic [16:0] GPIOIN,
    input  logic        PARITYSEL,
    output logic        PARITYERR,
    output logic        IRQ
);
    localparam int PW = $clog2(DEPTH) + 1;

    // Registered address phase
    logic        dp_valid_q, dp_valid_d;
    logic        dp_write_q, dp_write_d;
    logic [1:0]  dp_addr_q,  dp_addr_d;

    // Input capture pipeline
    logic [16:0] gin_q,  gin_d;
    logic [16:0] gin_qq, gin_qq_d;

    // Control and sticky status
    logic        ctrl_en_q, ctrl_en_d;
    logic        irq_en_q,  irq_en_d;
    logic        ovf_q,     ovf_d;
    logic        perr_q,    perr_d;

    logic        rd_act, wr_act, ctrl_wr, clr_wr;
    logic        change, evt_err, push_req, pop_req, flush;
    logic        fifo_full, fifo_empty;
    logic [PW-1:0] fifo_count;
    evt_t        push_evt, head_evt;
    logic [EVT_W-1:0] head_raw;

    logic        unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:3]};

    assign HREADYOUT = 1'b1;

    // Data-phase qualifiers
    assign rd_act  = dp_valid_q & ~dp_write_q;
    assign wr_act  = dp_valid_q &  dp_write_q;
    assign ctrl_wr = wr_act & (dp_addr_q == ADDR_CTRL);
    assign clr_wr  = wr_act & (dp_addr_q == ADDR_CLEAR);

    // Change detection compares the two most recent samples of the data bits;
    // parity covers all 17 sampled bits.
    assign change   = (gin_q[15:0] != gin_qq[15:0]);
    assign evt_err  = ((^gin_q) != PARITYSEL);
    assign push_req = ctrl_en_q & change;
    assign pop_req  = rd_act & (dp_addr_q == ADDR_DATA) & ~fifo_empty;
    assign flush    = clr_wr & HWDATA[CLR_FLUSH_BIT];

    assign push_evt = '{err: evt_err, data: gin_q[15:0]};
    assign head_evt = evt_t'(head_raw);

    evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush),
        .wdata (push_evt),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        // A new address phase only completes while the bus is ready.
        if (HREADY) begin
            dp_valid_d = HSEL & HTRANS[1];
            dp_write_d = HWRITE;
            dp_addr_d  = HADDR[3:2];
        end

        gin_d    = GPIOIN;
        gin_qq_d = gin_q;

        ctrl_en_d = ctrl_en_q;
        irq_en_d  = irq_en_q;
        if (ctrl_wr) begin
            ctrl_en_d = HWDATA[CTRL_EN_BIT];
            irq_en_d  = HWDATA[CTRL_IRQEN_BIT];
        end

        // Clear first, then set: a coincident set event wins.
        ovf_d = ovf_q;
        if (clr_wr & HWDATA[CLR_OVF_BIT]) ovf_d = 1'b0;
        if (push_req & fifo_full & ~pop_req & ~flush) ovf_d = 1'b1;

        perr_d = perr_q;
        if (clr_wr & HWDATA[CLR_PERR_BIT]) perr_d = 1'b0;
        if (push_req & evt_err) perr_d = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            gin_q      <= '0;
            gin_qq     <= '0;
            ctrl_en_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            gin_q      <= gin_d;
            gin_qq     <= gin_qq_d;
            ctrl_en_q  <= ctrl_en_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
        end
    end

    // Read mux: combinational from the registered address and current state.
    always_comb begin
        HRDATA = '0;
        if (rd_act) begin
            case (dp_addr_q)
                ADDR_DATA: begin
                    if (!fifo_empty) begin
                        HRDATA[EVT_W-1:0]     = head_evt;
                        HRDATA[DATA_VALID_BIT] = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    HRDATA[PW-1:0]          = fifo_count;
                    HRDATA[STATUS_OVF_BIT]  = ovf_q;
                    HRDATA[STATUS_PERR_BIT] = perr_q;
                end
                ADDR_CTRL: begin
                    HRDATA[CTRL_EN_BIT]    = ctrl_en_q;
                    HRDATA[CTRL_IRQEN_BIT] = irq_en_q;
                end
                default: HRDATA = '0;
            endcase
        end
    end

    assign PARITYERR = perr_q;
    assign IRQ       = irq_en_q & (~fifo_empty | ovf_q);

endmodule

// File: doc/ahb_gpio_evtfifo.md
# ahb_gpio_evtfifo

AHB-Lite subordinate that timestamps nothing but captures every change on the 17-bit GPIO input bus (16 data bits plus one parity bit), checks parity, and buffers the change events in a small FIFO for the CPU to drain. It is the responder end of the same AHB-Lite/GPIO signal set that the GPIO bench drives. It sits on the AHB-Lite bus beside the GPIO peripheral, decoded by HSEL, and raises IRQ when events are pending.

## Interface
- DEPTH, 8, FIFO entries (power of two, ≥2)
- PW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  subordinate select
- HADDR  in  32  address; only [3:2] decoded
- HTRANS  in  2  transfer type; NONSEQ/SEQ = HTRANS[1]
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  always 1 (zero wait states)
- HRDATA  out  32  read data (data phase)
- GPIOIN  in  17  [15:0] data, [16] parity bit
- PARITYSEL  in  1  0 = even parity, 1 = odd
- PARITYERR  out  1  sticky parity-error flag
- IRQ  out  1  interrupt request

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. Register addr[3:2] and HWRITE. Act in the next cycle (data phase).
- Registers, by HADDR[3:2]:
  - 0 DATA (RO): [15:0] event data, [16] event parity-error flag, [31] valid. A read with FIFO non-empty pops the head. A read when empty returns 0 and does not pop.
  - 1 STATUS (RO): [PW-1:0] count, [8] overflow (sticky), [9] PARITYERR (sticky).
  - 2 CTRL (RW): [0] enable, [1] irq_en. Other bits read 0.
  - 3 CLEAR (WO, reads 0): [0] flush FIFO, [1] clear overflow, [2] clear parity error.
- Writes to DATA and STATUS are ignored.
- Input capture:
  - gin_q <= GPIOIN every cycle; gin_qq <= gin_q every cycle, whether or not enable is set.
  - A change is gin_q[15:0] != gin_qq[15:0].
  - Parity is OK when ^gin_q == PARITYSEL; a mismatch is an error.
- When enable is 1 and a change occurs, push {err, gin_q[15:0]}.
- A parity error on any pushed event sets sticky PARITYERR.
- Full FIFO, push with no pop: the new event is dropped and overflow is set.
- Full FIFO, push and pop in the same cycle: both happen, count is unchanged, no overflow.
- Flush together with a push in the same cycle: flush wins, count becomes 0.
- Clear-bit write together with a set event in the same cycle: the set wins.
- IRQ = irq_en & ((count != 0) | overflow).

## Timing
- Reset values: HREADYOUT=1, HRDATA=0, PARITYERR=0, IRQ=0, count=0, pointers=0, CTRL=0, overflow=0, gin_q=gin_qq=0.
- GPIOIN changes before edge k → gin_q updated at edge k → push at edge k+1 → count visible to a STATUS read whose data phase follows edge k+1.
- HRDATA is combinational from the registered address and current state during the data phase.
- A DATA pop takes effect at the edge ending that data phase.
- Back-to-back DATA reads pop consecutive entries, one per cycle.
- A CTRL/CLEAR write takes effect at the edge ending its data phase, using HWDATA.
- An event arriving the cycle after enable is written is captured.
- HRESET asserted mid-transfer: the pending data phase is discarded and the FIFO is emptied.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.

## Structure
- Package ahb_gpio_evtfifo_pkg holds:
  - register offset localparams (DATA=2'd0, STATUS=2'd1, CTRL=2'd2, CLEAR=2'd3)
  - bit-position constants
  - typedef for the 17-bit event struct {err, data[15:0]}
- One sub-module, evt_fifo: synchronous FIFO with push/pop/flush/full/empty/count, parameterised by DEPTH and width.
- Top level holds AHB decode, input capture, parity check, sticky flags and IRQ.

## Test plan
- Reset, then read STATUS, CTRL and DATA → all 0x0000_0000. IRQ=0, PARITYERR=0.
- CTRL=0x3, PARITYSEL=0, GPIOIN 0→0x0_0003 (even parity OK) → STATUS=0x1, IRQ=1; DATA read=0x8000_0003; STATUS=0, IRQ=0.
- PARITYSEL=0, GPIOIN=0x0_0001 (odd, parity bit 0) → DATA=0x8001_0001, PARITYERR=1, STATUS bit9=1. CLEAR=0x4 → PARITYERR=0.
- 9 distinct changes with no reads (DEPTH=8) → STATUS count=8, bit8=1. Eight DATA reads return the first 8 values in order; ninth read=0. CLEAR=0x2 → IRQ=0.
- FIFO full, and a DATA pop coincides with a new event → count stays 8, overflow stays 0.
- CTRL.enable=0, toggle GPIOIN → count stays 0. CLEAR=0x1 while 3 entries are held → count=0.
